// File: rtl/pcie_us_rq_seq_num_merge_pkg.sv
// Shared constants for the RQ sequence-number merge block: lane widths for the
// two hard-IP generations, the smallest usable FIFO depth and status widths.
package pcie_us_rq_seq_num_merge_pkg;

    localparam int RQ_SEQ_NUM_WIDTH_USP     = 6;   // UltraScale+ hard IP
    localparam int RQ_SEQ_NUM_WIDTH_US      = 4;   // UltraScale hard IP
    localparam int RQ_SEQ_NUM_WIDTH_DEFAULT = RQ_SEQ_NUM_WIDTH_USP;

    // Two pushes land at wr_ptr and wr_ptr+1, so tiny FIFOs make no sense.
    localparam int FIFO_DEPTH_MIN           = 4;
    localparam int DROP_COUNT_WIDTH_DEFAULT = 16;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pcie_us_rq_seq_num_merge_if.sv
// Stream bundle between the hard-IP sequence-number lanes, the merge block and
// the single-lane consumer. The merge block uses the slave view; the
// environment (hard IP plus consumer) uses the master view.
interface pcie_us_rq_seq_num_merge_if #(
    parameter int RQ_SEQ_NUM_WIDTH = 6
);
    logic [RQ_SEQ_NUM_WIDTH-1:0] s_axis_rq_seq_num_0;
    logic                        s_axis_rq_seq_num_valid_0;
    logic [RQ_SEQ_NUM_WIDTH-1:0] s_axis_rq_seq_num_1;
    logic                        s_axis_rq_seq_num_valid_1;
    logic [RQ_SEQ_NUM_WIDTH-1:0] m_axis_seq_num_tdata;
    logic                        m_axis_seq_num_tvalid;
    logic                        m_axis_seq_num_tready;

    modport slave (
        input  s_axis_rq_seq_num_0, s_axis_rq_seq_num_valid_0,
        input  s_axis_rq_seq_num_1, s_axis_rq_seq_num_valid_1,
        input  m_axis_seq_num_tready,
        output m_axis_seq_num_tdata, m_axis_seq_num_tvalid
    );

    modport master (
        output s_axis_rq_seq_num_0, s_axis_rq_seq_num_valid_0,
        output s_axis_rq_seq_num_1, s_axis_rq_seq_num_valid_1,
        output m_axis_seq_num_tready,
        input  m_axis_seq_num_tdata, m_axis_seq_num_tvalid
    );
endinterface

// File: rtl/pcie_us_rq_seq_num_merge_seq_num_fifo_ram.sv
// Register-file storage for the merge FIFO: two write ports (always at
// distinct consecutive addresses) and one asynchronous read port.
module pcie_us_rq_seq_num_merge_seq_num_fifo_ram #(
    parameter int WIDTH  = 6,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  data_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  data_b,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next-state of every entry: port A, else port B, else hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_a && (addr_a == ADDR_W'(i))) begin
                mem_d[i] = data_a;
            end else if (we_b && (addr_b == ADDR_W'(i))) begin
                mem_d[i] = data_b;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Storage array; cleared on reset so no stale data is ever observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pcie_us_rq_seq_num_merge.sv
// Merges the two non-backpressurable RQ sequence-number lanes into one
// flow-controlled stream through a small FIFO, with drop statistics.
module pcie_us_rq_seq_num_merge
    import pcie_us_rq_seq_num_merge_pkg::*;
#(
    parameter int RQ_SEQ_NUM_WIDTH = RQ_SEQ_NUM_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH       = 32,
    parameter int DROP_COUNT_WIDTH = DROP_COUNT_WIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pcie_us_rq_seq_num_merge_if.slave     seq_if,
    input  logic                          status_clear,
    output logic                          status_overflow,
    output logic [DROP_COUNT_WIDTH-1:0]   status_drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   status_level
);

    localparam int PTR_W  = ptr_width(FIFO_DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam int SUM_W  = DROP_COUNT_WIDTH + 1;

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic                        overflow_q, overflow_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic [PTR_W-1:0]            level_s;
    logic [PTR_W-1:0]            free_s;
    logic                        we_a_s, we_b_s;
    logic [RQ_SEQ_NUM_WIDTH-1:0] data_a_s;
    logic [1:0]                  push_cnt_s;
    logic [1:0]                  drop_s;
    logic                        pop_s;
    logic [SUM_W-1:0]            drop_sum_s;
    logic [ADDR_W-1:0]           addr_a_s, addr_b_s;
    logic [RQ_SEQ_NUM_WIDTH-1:0] head_s;

    // Occupancy and room come only from registered pointers, so a same-cycle
    // pop never makes room for that cycle's pushes.
    assign level_s = wr_ptr_q - rd_ptr_q;
    assign free_s  = PTR_W'(FIFO_DEPTH) - level_s;

    // Admission: lane 0 always takes the first free slot; a lone lane 1 takes
    // it instead. Whatever does not fit is dropped.
    always_comb begin
        we_a_s     = 1'b0;
        we_b_s     = 1'b0;
        data_a_s   = seq_if.s_axis_rq_seq_num_0;
        push_cnt_s = 2'd0;
        drop_s     = 2'd0;
        case ({seq_if.s_axis_rq_seq_num_valid_1, seq_if.s_axis_rq_seq_num_valid_0})
            2'b01, 2'b10: begin
                data_a_s = seq_if.s_axis_rq_seq_num_valid_0 ? seq_if.s_axis_rq_seq_num_0
                                                            : seq_if.s_axis_rq_seq_num_1;
                if (free_s != PTR_W'(0)) begin
                    we_a_s     = 1'b1;
                    push_cnt_s = 2'd1;
                end else begin
                    drop_s = 2'd1;
                end
            end
            2'b11: begin
                if (free_s >= PTR_W'(2)) begin
                    we_a_s     = 1'b1;
                    we_b_s     = 1'b1;
                    push_cnt_s = 2'd2;
                end else if (free_s == PTR_W'(1)) begin
                    we_a_s     = 1'b1;
                    push_cnt_s = 2'd1;
                    drop_s     = 2'd1;
                end else begin
                    drop_s = 2'd2;
                end
            end
            default: begin
                push_cnt_s = 2'd0;
            end
        endcase
    end

    // Pointer advance and saturating drop statistics; clear beats a drop.
    always_comb begin
        pop_s      = (level_s != PTR_W'(0)) && seq_if.m_axis_seq_num_tready;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_cnt_s);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_s);
        drop_sum_s = {1'b0, drop_cnt_q} + SUM_W'(drop_s);
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (status_clear) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop_s != 2'd0) begin
            overflow_d = 1'b1;
            drop_cnt_d = drop_sum_s[SUM_W-1] ? {DROP_COUNT_WIDTH{1'b1}}
                                              : drop_sum_s[DROP_COUNT_WIDTH-1:0];
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Pointer and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign addr_a_s = wr_ptr_q[ADDR_W-1:0];
    assign addr_b_s = addr_a_s + ADDR_W'(1);

    pcie_us_rq_seq_num_merge_seq_num_fifo_ram #(
        .WIDTH (RQ_SEQ_NUM_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_a   (we_a_s),
        .addr_a (addr_a_s),
        .data_a (data_a_s),
        .we_b   (we_b_s),
        .addr_b (addr_b_s),
        .data_b (seq_if.s_axis_rq_seq_num_1),
        .rd_addr(rd_ptr_q[ADDR_W-1:0]),
        .rd_data(head_s)
    );

    // Outputs depend only on registered state; pushes never touch the head slot.
    assign seq_if.m_axis_seq_num_tvalid = (level_s != PTR_W'(0));
    assign seq_if.m_axis_seq_num_tdata  = head_s;
    assign status_level                 = level_s;
    assign status_overflow              = overflow_q;
    assign status_drop_count            = drop_cnt_q;

endmodule

// File: tb/tb_pcie_us_rq_seq_num_merge.sv
// Randomised and directed bench for the RQ sequence-number merge block,
// checked against a queue-based model of the FIFO and its drop statistics.
module tb_pcie_us_rq_seq_num_merge;

    localparam int W     = 6;
    localparam int DEPTH = 32;
    localparam int DCW   = 16;
    localparam int CMAX  = 65535;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             status_clear = 1'b0;
    logic             status_overflow;
    logic [DCW-1:0]   status_drop_count;
    logic [5:0]       status_level;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state.
    int m_q[$];
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    pcie_us_rq_seq_num_merge_if #(.RQ_SEQ_NUM_WIDTH(W)) bus ();

    pcie_us_rq_seq_num_merge #(
        .RQ_SEQ_NUM_WIDTH(W),
        .FIFO_DEPTH      (DEPTH),
        .DROP_COUNT_WIDTH(DCW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .seq_if           (bus),
        .status_clear     (status_clear),
        .status_overflow  (status_overflow),
        .status_drop_count(status_drop_count),
        .status_level     (status_level)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("tvalid", 32'(bus.m_axis_seq_num_tvalid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("tdata", 32'(bus.m_axis_seq_num_tdata), 32'(m_q[0]));
        chk("level", 32'(status_level), 32'(m_q.size()));
        chk("overflow", 32'(status_overflow), 32'(m_ovf));
        chk("drop_count", 32'(status_drop_count), 32'(m_cnt));
    endtask

    // One clock: drive inputs, advance the model, clock, then compare.
    task automatic cycle(input bit v0, input int d0, input bit v1, input int d1,
                         input bit rdy, input bit clr);
        int free_n, nvalid, acc, drops;
        bus.s_axis_rq_seq_num_valid_0 = v0;
        bus.s_axis_rq_seq_num_0       = W'(d0);
        bus.s_axis_rq_seq_num_valid_1 = v1;
        bus.s_axis_rq_seq_num_1       = W'(d1);
        bus.m_axis_seq_num_tready     = rdy;
        status_clear                  = clr;

        free_n = DEPTH - m_q.size();
        nvalid = int'(v0) + int'(v1);
        acc    = (nvalid < free_n) ? nvalid : free_n;
        drops  = nvalid - acc;
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (acc >= 1) m_q.push_back(v0 ? (d0 % 64) : (d1 % 64));
        if (acc == 2) m_q.push_back(d1 % 64);
        if (clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (drops > 0) begin
            m_ovf = 1'b1;
            m_cnt = (m_cnt + drops > CMAX) ? CMAX : m_cnt + drops;
        end

        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && m_q.size() != 0; i++) cycle(0, 0, 0, 0, 1, 0);
        chk("drain_empty", 32'(bus.m_axis_seq_num_tvalid), 32'd0);
    endtask

    initial begin
        bus.s_axis_rq_seq_num_0       = '0;
        bus.s_axis_rq_seq_num_valid_0 = 1'b0;
        bus.s_axis_rq_seq_num_1       = '0;
        bus.s_axis_rq_seq_num_valid_1 = 1'b0;
        bus.m_axis_seq_num_tready     = 1'b0;

        // Reset state.
        #22;
        check_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single lane-0 entry, then pop.
        cycle(1, 5, 0, 0, 0, 0);
        chk("single_data", 32'(bus.m_axis_seq_num_tdata), 32'd5);
        chk("single_level", 32'(status_level), 32'd1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("single_popped", 32'(status_level), 32'd0);

        // Dual push with ready: 10 then 11.
        cycle(1, 10, 1, 11, 1, 0);
        chk("dual_first", 32'(bus.m_axis_seq_num_tdata), 32'd10);
        cycle(0, 0, 0, 0, 1, 0);
        chk("dual_second", 32'(bus.m_axis_seq_num_tdata), 32'd11);
        cycle(0, 0, 0, 0, 1, 0);

        // Lone lane 1 takes the next slot.
        cycle(0, 0, 1, 33, 0, 0);
        chk("lane1_only", 32'(bus.m_axis_seq_num_tdata), 32'd33);
        drain();

        // Fill to full, then overflow by two.
        for (int i = 0; i < 16; i++) cycle(1, 2 * i, 1, 2 * i + 1, 0, 0);
        chk("full_level", 32'(status_level), 32'd32);
        chk("full_no_ovf", 32'(status_overflow), 32'd0);
        cycle(1, 50, 1, 51, 0, 0);
        chk("ovf_count", 32'(status_drop_count), 32'd2);
        chk("ovf_head", 32'(bus.m_axis_seq_num_tdata), 32'd0);

        // Level 31 with both lanes: one stored, one dropped.
        cycle(0, 0, 0, 0, 1, 0);
        chk("lvl31", 32'(status_level), 32'd31);
        cycle(1, 40, 1, 41, 0, 0);
        chk("lvl31_count", 32'(status_drop_count), 32'd3);
        chk("lvl31_level", 32'(status_level), 32'd32);

        // Full-minus-one with dual push and a pop in the same cycle.
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 42, 1, 43, 1, 0);
        chk("fm1_pop_count", 32'(status_drop_count), 32'd4);

        // Sustained overflow until the counter saturates.
        for (int i = 0; i < 32770; i++) cycle(1, i, 1, i + 1, 0, 0);
        chk("sat_count", 32'(status_drop_count), 32'hFFFF);
        cycle(1, 1, 0, 0, 0, 0);
        chk("sat_hold", 32'(status_drop_count), 32'hFFFF);
        cycle(1, 1, 1, 2, 0, 1);
        chk("clear_beats_drop", 32'(status_drop_count), 32'd0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("clear_ovf", 32'(status_overflow), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 2));
        end

        // Asynchronous reset mid-stream at level 7.
        drain();
        for (int i = 0; i < 3; i++) cycle(1, 20 + 2 * i, 1, 21 + 2 * i, 0, 0);
        cycle(1, 26, 0, 0, 0, 0);
        chk("pre_rst_level", 32'(status_level), 32'd7);
        bus.s_axis_rq_seq_num_valid_0 = 1'b0;
        bus.s_axis_rq_seq_num_valid_1 = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_tvalid", 32'(bus.m_axis_seq_num_tvalid), 32'd0);
        chk("async_level", 32'(status_level), 32'd0);
        m_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        cycle(1, 7, 1, 8, 0, 0);
        chk("post_rst_data", 32'(bus.m_axis_seq_num_tdata), 32'd7);
        chk("post_rst_level", 32'(status_level), 32'd2);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
